// File: rtl/v_upd_ingress_if.sv
// Shared payload types and the ingress bus bundle between the upstream update
// source, the ingress FIFO and the list engine.
package v_pkg;
    typedef logic [3:0] id_t;
    typedef logic [1:0] cmd_t;
    typedef logic [7:0] key_t;
    typedef logic [7:0] size_t;
endpackage

// Handshake: a word moves on a rising edge where i_in_vld && o_in_rdy; while
// o_in_rdy is low the source holds the word. o_upd_vld_r is a one-cycle pulse
// per issued word with no back-pressure.
interface v_upd_ingress_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic          i_in_vld;
    logic          o_in_rdy;
    v_pkg::id_t    i_in_prod_id;
    v_pkg::cmd_t   i_in_cmd;
    v_pkg::key_t   i_in_key;
    v_pkg::size_t  i_in_size;
    logic          i_busy;
    logic          o_upd_vld_r;
    v_pkg::id_t    o_upd_prod_id_r;
    v_pkg::cmd_t   o_upd_cmd_r;
    v_pkg::key_t   o_upd_key_r;
    v_pkg::size_t  o_upd_size_r;
    logic [LW-1:0] o_level_r;
    logic          o_empty_r;
    logic          o_full_r;

    modport master (
        output i_in_vld, i_in_prod_id, i_in_cmd, i_in_key, i_in_size, i_busy,
        input  o_in_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r,
               o_upd_key_r, o_upd_size_r, o_level_r, o_empty_r, o_full_r
    );

    modport slave (
        input  i_in_vld, i_in_prod_id, i_in_cmd, i_in_key, i_in_size, i_busy,
        output o_in_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r,
               o_upd_key_r, o_upd_size_r, o_level_r, o_empty_r, o_full_r
    );
endinterface

// File: rtl/v_upd_ingress.sv
// Update ingress FIFO: buffers upstream list updates while the list engine is
// initialising and issues them one per cycle, in order, with registered outputs.
module v_upd_ingress #(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    v_upd_ingress_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    typedef struct packed {
        v_pkg::id_t   prod_id;
        v_pkg::cmd_t  cmd;
        v_pkg::key_t  key;
        v_pkg::size_t size;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          upd_vld_q;
    entry_t        upd_q;
    entry_t        in_word;
    logic          push;
    logic          pop;

    assign in_word = '{prod_id: bus.i_in_prod_id, cmd: bus.i_in_cmd,
                       key: bus.i_in_key, size: bus.i_in_size};

    // Ready and pop decisions come from registered flags only; i_busy gates the
    // pop combinationally so a rising busy stalls issue on that very edge.
    assign push = bus.i_in_vld && !full_q;
    assign pop  = !empty_q && !bus.i_busy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LW'(DEPTH));
    end

    // Storage carries no reset: the level counter guarantees a slot is
    // written before it can be read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            upd_vld_q <= 1'b0;
            upd_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            upd_vld_q <= pop;
            if (pop) begin
                upd_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign bus.o_in_rdy        = !full_q;
    assign bus.o_upd_vld_r     = upd_vld_q;
    assign bus.o_upd_prod_id_r = upd_q.prod_id;
    assign bus.o_upd_cmd_r     = upd_q.cmd;
    assign bus.o_upd_key_r     = upd_q.key;
    assign bus.o_upd_size_r    = upd_q.size;
    assign bus.o_level_r       = level_q;
    assign bus.o_empty_r       = empty_q;
    assign bus.o_full_r        = full_q;
endmodule

// File: tb/tb_v_upd_ingress.sv
// Bench for v_upd_ingress: directed scenarios plus random traffic against an
// occupancy-count model and an in-order expected-word queue.
module tb_v_upd_ingress;
  localparam int DEPTH = 4;
  localparam int W = 22;

  logic clk;
  logic rst;

  v_upd_ingress_if #(.DEPTH(DEPTH)) bus ();

  v_upd_ingress #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // scoreboard / model state
  logic [W-1:0] exp_q[$];
  int mdl_level;
  bit exp_vld;
  logic [W-1:0] last_w;
  int total;
  int bad;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    mdl_level = 0;
    exp_vld = 1'b0;
    last_w = '0;
  endtask

  // reference model: occupancy arithmetic and ordered queue of accepted words
  always @(posedge clk) begin
    int acc;
    int pp;
    if (rst) begin
      acc = (bus.i_in_vld && mdl_level < DEPTH) ? 1 : 0;
      pp = (mdl_level > 0 && !bus.i_busy) ? 1 : 0;
      if (acc == 1)
        exp_q.push_back({bus.i_in_prod_id, bus.i_in_cmd, bus.i_in_key, bus.i_in_size});
      mdl_level = mdl_level + acc - pp;
      exp_vld = (pp == 1);
    end
  end

  // monitor: compares DUT outputs to the model away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] w;
    got = {bus.o_upd_prod_id_r, bus.o_upd_cmd_r, bus.o_upd_key_r, bus.o_upd_size_r};
    if (!rst) begin
      check("rst_vld", 32'(bus.o_upd_vld_r), 0);
      check("rst_level", 32'(bus.o_level_r), 0);
      check("rst_empty", 32'(bus.o_empty_r), 1);
      check("rst_full", 32'(bus.o_full_r), 0);
      check("rst_rdy", 32'(bus.o_in_rdy), 1);
      check("rst_payload", 32'(got), 0);
    end else begin
      check("rdy", 32'(bus.o_in_rdy), 32'(mdl_level < DEPTH));
      check("level", 32'(bus.o_level_r), 32'(mdl_level));
      check("empty", 32'(bus.o_empty_r), 32'(mdl_level == 0));
      check("full", 32'(bus.o_full_r), 32'(mdl_level == DEPTH));
      check("upd_vld", 32'(bus.o_upd_vld_r), 32'(exp_vld));
      if (exp_vld) begin
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check("payload", 32'(got), 32'(w));
          last_w = w;
        end
      end else begin
        check("payload_hold", 32'(got), 32'(last_w));
      end
    end
  end

  // driver: present inputs for one clock cycle
  task automatic drive(input bit v, input logic [W-1:0] w, input bit b);
    @(negedge clk);
    bus.i_in_vld = v;
    {bus.i_in_prod_id, bus.i_in_cmd, bus.i_in_key, bus.i_in_size} = w;
    bus.i_busy = b;
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) drive(1'b0, '0, b);
  endtask

  logic [W-1:0] words[5];

  initial begin
    total = 0;
    bad = 0;
    model_clear();
    rst = 1'b0;
    bus.i_in_vld = 1'b0;
    {bus.i_in_prod_id, bus.i_in_cmd, bus.i_in_key, bus.i_in_size} = '0;
    bus.i_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // single word, two-cycle latency
    drive(1'b1, {4'd3, 2'd1, 8'h10, 8'd5}, 1'b0);
    idle(3, 1'b0);

    // fill while busy, fifth word held off, then drain
    for (int i = 0; i < 5; i++) words[i] = W'($urandom);
    for (int i = 0; i < 5; i++) drive(1'b1, words[i], 1'b1);
    drive(1'b1, words[4], 1'b1);
    idle(6, 1'b0);

    // steady level 2 with simultaneous push and pop, pointers wrap
    drive(1'b1, W'($urandom), 1'b1);
    drive(1'b1, W'($urandom), 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, W'($urandom), 1'b0);
    idle(4, 1'b0);

    // asynchronous reset while a pulse is out and three words are buffered
    for (int i = 0; i < 4; i++) drive(1'b1, W'($urandom), 1'b1);
    drive(1'b0, '0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_vld", 32'(bus.o_upd_vld_r), 1);
    check("pre_rst_level", 32'(bus.o_level_r), 3);
    rst = 1'b0;
    model_clear();
    #1;
    check("async_rst_vld", 32'(bus.o_upd_vld_r), 0);
    check("async_rst_level", 32'(bus.o_level_r), 0);
    check("async_rst_empty", 32'(bus.o_empty_r), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(4, 1'b0);

    // busy toggling around pending entries
    drive(1'b1, W'($urandom), 1'b1);
    drive(1'b1, W'($urandom), 1'b1);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    idle(3, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) == 0));
    end
    idle(DEPTH + 3, 1'b0);

    @(negedge clk);
    check("drain_exp_q", 32'(exp_q.size()), 0);
    check("drain_level", 32'(bus.o_level_r), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
